sram_like_bram_bridge: RTL



---
 rtl/sram_like_bram_bridge_pkg.sv | 18 +
 rtl/sram_like_bram_bridge_fifo.sv | 67 ++++++
 rtl/sram_like_bram_bridge.sv | 97 +++++++++
 3 files changed

// File: rtl/sram_like_bram_bridge_pkg.sv
// Shared definitions for the SRAM-like to BRAM bridge: transfer size codes,
// default stall-LFSR seed and the LFSR step function.
package sram_like_bram_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (1-based), shifting toward the MSB.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/sram_like_bram_bridge_fifo.sv
// Synchronous response FIFO with zero-latency head read; module name is
// sram_resp_fifo and it is used by the bridge top to order responses.
module sram_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/sram_like_bram_bridge.sv
// Slave side of the SRAM-like req/addr_ok/data_ok handshake, mapped onto a
// single-port BRAM with 1-cycle read latency; responses return in order.
module sram_like_bram_bridge
  import sram_like_bram_bridge_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 2,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic             inflight_q, inflight_d;
  logic             inflight_wr_q, inflight_wr_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_head, push_data;
  logic [CNT_W:0]   occ;
  logic             addr_stall, data_stall, handshake;
  logic             unused_bits;

  assign addr_stall = STALL_EN & lfsr_q[0] & lfsr_q[1];
  assign data_stall = STALL_EN & lfsr_q[2] & lfsr_q[3];

  // Occupancy counts the access still inside the BRAM, so a capture push
  // always finds room. A pop in this cycle is deliberately not credited.
  assign occ     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign addr_ok = ~reset & (occ < (CNT_W + 1)'(DEPTH)) & ~addr_stall;
  assign busy    = (occ != '0);

  assign handshake  = req & addr_ok;
  assign bram_en    = handshake;
  assign bram_we    = (handshake & wr) ? wstrb : 4'b0000;
  assign bram_addr  = addr[ADDR_W+1:2];
  assign bram_wdata = wdata;

  assign push_data = inflight_wr_q ? 32'h0 : bram_rdata;
  assign data_ok   = ~reset & ~fifo_empty & ~data_stall;
  assign rdata     = data_ok ? fifo_head : 32'h0;

  // size is informational and the upper/lower address bits are ignored.
  assign unused_bits = ^{size, addr, fifo_full};

  always_comb begin
    lfsr_d        = lfsr16_next(lfsr_q);
    inflight_d    = handshake;
    inflight_wr_d = handshake ? wr : inflight_wr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= LFSR_SEED;
      inflight_q    <= 1'b0;
      inflight_wr_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      inflight_q    <= inflight_d;
      inflight_wr_q <= inflight_wr_d;
    end
  end

  sram_resp_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (data_ok),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
